md_stall_ctrl: RTL and testbench
================================

// Module: md_stall_ctrl
// PURPOSE
//   Sequences the multi-cycle multiply/divide unit and owns the HI/LO registers.
//   Tracks the unit's busy countdown and drives the stall/flush controls for the F/D/E pipeline registers.
//   Sits beside the E stage; its stall outputs feed the halt inputs of the fd/de pipeline registers.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//   clk       in   1   clock, all state updates on rising edge
//   reset     in   1   synchronous, active-high
//   e_start   in   1   E-stage instr is a valid MD op this cycle
//   e_op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op
//   e_rs      in   32  operand A (forwarded rs value)
//   e_rt      in   32  operand B (forwarded rt value)
//   d_useMd   in   1   D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//   hi        out  32  HI register
//   lo        out  32  LO register
//   busy      out  1   unit computing
//   f_halt    out  1   hold PC / fd_reg
//   d_halt    out  1   hold de_reg inputs (D instr stays)
//   e_flush   out  1   insert bubble into de_reg
// BEHAVIOUR
//   Reset values: hi=0, lo=0, busy=0, state=IDLE, cnt=0; f_halt/d_halt/e_flush follow busy/e_start combinationally (0 when idle).
//   Reset mid-operation aborts the op: state IDLE, hi/lo cleared, result discarded.
//   FSM IDLE -> BUSY: edge where e_start=1 and e_op in {0..3}; latch e_rs/e_rt/e_op; cnt <= N-1 (N = MULT_CYCLES or DIV_CYCLES).
//   BUSY: cnt decrements each cycle; busy=1 throughout.
//   BUSY -> IDLE: at the edge where cnt==0 in BUSY, write hi/lo.
//   Timing: op accepted at edge 0 -> busy=1 for exactly N cycles -> new hi/lo visible the cycle after busy falls.
//   MTHI/MTLO (e_op 4/5), e_start in IDLE: hi/lo <= e_rs next edge. No busy.
//   e_start while BUSY: ignored (cannot occur when stalls honoured); no state change.
//   e_op 6/7 with e_start: no effect.
//   Arithmetic:
//     MULT: {hi,lo} = $signed(A)*$signed(B), 64-bit.
//     MULTU: same, unsigned.
//     DIV: lo = A/B, hi = A%B, signed; quotient truncates toward zero, remainder takes dividend sign.
//     DIVU: same, unsigned.
//     B==0 on DIV/DIVU: full N busy cycles, then hi/lo unchanged.
//   Stall: stall = d_useMd & (busy | (e_start & e_op<=3)).
//     f_halt = d_halt = e_flush = stall (combinational, same cycle).
//   Stall boundary: on the final BUSY cycle stall is still 1; it drops the cycle after.
//   Back-to-back ops: an op in D stalls until the unit is IDLE, then issues. No overlap.
// CONFIGURATION
//   MD_STALL_CNT_EN:
//     Defined: adds output stall_cnt [31:0]. Counts cycles with stall=1, saturates at 32'hFFFFFFFF, cleared by reset.
//     Not defined: port and counter absent; all other behaviour identical.
// TESTING
//   reset=1 one edge mid-DIV -> hi=lo=0, busy=0 next cycle.
//   MULT A=32'hFFFFFFFE (-2), B=3 -> busy 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
//   MULTU A=32'hFFFFFFFF, B=2 -> hi=1, lo=32'hFFFFFFFE after 5 busy cycles.
//   DIV A=-7, B=2 -> busy 10 cycles; then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
//   DIV B=0 with hi=5, lo=6 -> busy 10 cycles; hi=5, lo=6 unchanged.
//   MULT accepted, d_useMd=1 (mflo) -> f_halt/d_halt/e_flush=1 for the start cycle plus 5 busy cycles (6 total), then 0.
//     With MD_STALL_CNT_EN: stall_cnt=6.

Source files
------------

// File: rtl/md_stall_ctrl.sv
// Multiply/divide sequencer that owns the HI/LO registers and drives the F/D/E stall controls.
// Latency: MULT/MULTU take MULT_CYCLES busy cycles and DIV/DIVU take DIV_CYCLES; MTHI/MTLO take effect at the next edge.
// Backpressure: stall = d_useMd & (busy | MD op starting in E). Optional MD_STALL_CNT_EN adds the stall_cnt output.
module md_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_useMd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        f_halt,
    output logic        d_halt,
    output logic        e_flush
`ifdef MD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [31:0] MULT_LAST = 32'(MULT_CYCLES - 1);
    localparam logic [31:0] DIV_LAST  = 32'(DIV_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        accept;
    logic        stall;

    logic signed [63:0] sa64, sb64;
    logic signed [32:0] sa33, sb33;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;

    // Only ops 0-3 start the sequencer; e_op[2]==0 covers exactly that range.
    assign accept = (state == IDLE) && e_start && !e_op[2];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: if (cnt == 32'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state == BUSY);
        stall   = d_useMd && (busy || (e_start && !e_op[2]));
        f_halt  = stall;
        d_halt  = stall;
        e_flush = stall;
    end

    // Signed division runs at 33 bits so that -2^31 / -1 wraps to a defined value.
    assign sa64 = {{32{a_q[31]}}, a_q};
    assign sb64 = {{32{b_q[31]}}, b_q};
    assign sa33 = {a_q[31], a_q};
    assign sb33 = {b_q[31], b_q};

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        res_wr = 1'b1;
        case (op_q)
            2'd0: {res_hi, res_lo} = sa64 * sb64;
            2'd1: {res_hi, res_lo} = {32'd0, a_q} * {32'd0, b_q};
            2'd2: begin
                res_lo = 32'(sa33 / sb33);
                res_hi = 32'(sa33 % sb33);
            end
            default: begin
                res_lo = a_q / b_q;
                res_hi = a_q % b_q;
            end
        endcase
        // A zero divisor still burns the full busy time but leaves HI/LO alone.
        if (op_q[1] && (b_q == 32'd0)) res_wr = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 32'd0;
            op_q <= 2'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else if (accept) begin
            op_q <= e_op[1:0];
            a_q  <= e_rs;
            b_q  <= e_rt;
            cnt  <= e_op[1] ? DIV_LAST : MULT_LAST;
        end else if (state == BUSY) begin
            if (cnt == 32'd0) begin
                if (res_wr) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else begin
                cnt <= cnt - 32'd1;
            end
        end else if (e_start && e_op == 3'd4) begin
            hi <= e_rs;
        end else if (e_start && e_op == 3'd5) begin
            lo <= e_rs;
        end
    end

`ifdef MD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Bench for md_stall_ctrl: directed spec scenarios plus a randomized run against a cycle-count reference model.
module tb_md_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_start;
    logic [2:0]  e_op;
    logic [31:0] e_rs, e_rt;
    logic        d_useMd;
    logic [31:0] hi, lo;
    logic        busy, f_halt, d_halt, e_flush;
`ifdef MD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pwr;
    int          m_left;
    logic [31:0] m_scnt;

    md_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .e_start(e_start), .e_op(e_op),
        .e_rs(e_rs), .e_rt(e_rt), .d_useMd(d_useMd),
        .hi(hi), .lo(lo), .busy(busy),
        .f_halt(f_halt), .d_halt(d_halt), .e_flush(e_flush)
`ifdef MD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl, output bit wr);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        wr = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            3'd0: begin sp = sa * sb; v = sp; rh = v[63:32]; rl = v[31:0]; end
            3'd1: begin up = ua * ub; v = up; rh = v[63:32]; rl = v[31:0]; end
            3'd2: if (b == 0) wr = 1'b0;
                  else begin
                      sq = sa / sb; sr = sa % sb;
                      v = sq; rl = v[31:0];
                      v = sr; rh = v[31:0];
                  end
            default: if (b == 0) wr = 1'b0;
                  else begin rl = 32'(ua / ub); rh = 32'(ua % ub); end
        endcase
    endtask

    function automatic bit exp_stall();
        return d_useMd && (m_left > 0 || (e_start && e_op <= 3'd3));
    endfunction

    // Advance the model by one clock edge using the currently driven inputs, then the DUT.
    task automatic tick();
        bit s;
        s = exp_stall();
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pwr = 0; m_scnt = 0;
        end else begin
            if (s && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (e_start) begin
                if (e_op <= 3'd3) begin
                    m_left = (e_op <= 3'd1) ? MULT_N : DIV_N;
                    compute(e_op, e_rs, e_rt, m_phi, m_plo, m_pwr);
                end else if (e_op == 3'd4) m_hi = e_rs;
                else if (e_op == 3'd5) m_lo = e_rs;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit use_md);
        e_start = st; e_op = op; e_rs = a; e_rt = b; d_useMd = use_md;
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    endtask

    // Issue one op, then count busy cycles (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy);
        drive(1'b1, op, a, b, 1'b0);
        tick();
        idle_inputs();
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 50) begin
            nbusy++;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (hi !== 32'd0) $display("FAIL reset_hi got=%h want=0", hi); else n_pass++;
        n_total++; if (lo !== 32'd0) $display("FAIL reset_lo got=%h want=0", lo); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_total++; if ({f_halt, d_halt, e_flush} !== 3'b000)
            $display("FAIL reset_stall got=%b want=000", {f_halt, d_halt, e_flush}); else n_pass++;
`ifdef MD_STALL_CNT_EN
        n_total++; if (stall_cnt !== 32'd0) $display("FAIL reset_scnt got=%0d want=0", stall_cnt); else n_pass++;
`endif
    endtask

    task automatic test_mult();
        int nb;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, nb);
        n_total++; if (nb != MULT_N) $display("FAIL mult_busy got=%0d want=%0d", nb, MULT_N); else n_pass++;
        n_total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA)
            $display("FAIL mult_res got=%h_%h want=ffffffff_fffffffa", hi, lo); else n_pass++;
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, nb);
        n_total++; if (nb != MULT_N) $display("FAIL multu_busy got=%0d want=%0d", nb, MULT_N); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE)
            $display("FAIL multu_res got=%h_%h want=00000001_fffffffe", hi, lo); else n_pass++;
    endtask

    task automatic test_div();
        int nb;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb);
        n_total++; if (nb != DIV_N) $display("FAIL div_busy got=%0d want=%0d", nb, DIV_N); else n_pass++;
        n_total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got=%h want=fffffffd", lo); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got=%h want=ffffffff", hi); else n_pass++;
    endtask

    task automatic test_div_zero();
        int nb;
        drive(1'b1, 3'd4, 32'd5, 32'd0, 1'b0); tick();
        drive(1'b1, 3'd5, 32'd6, 32'd0, 1'b0); tick();
        n_total++; if ({hi, lo} !== {32'd5, 32'd6}) $display("FAIL mthi_mtlo got=%h_%h want=5_6", hi, lo); else n_pass++;
        run_op(3'd2, 32'd100, 32'd0, nb);
        n_total++; if (nb != DIV_N) $display("FAIL divz_busy got=%0d want=%0d", nb, DIV_N); else n_pass++;
        n_total++; if ({hi, lo} !== {32'd5, 32'd6}) $display("FAIL divz_res got=%h_%h want=5_6", hi, lo); else n_pass++;
    endtask

    task automatic test_ignored();
        int nb;
        drive(1'b1, 3'd0, 32'd7, 32'd9, 1'b0); tick();
        drive(1'b1, 3'd4, 32'd123, 32'd0, 1'b0); tick();   // MTHI while busy
        drive(1'b1, 3'd2, 32'd50, 32'd5, 1'b0); tick();    // DIV while busy
        idle_inputs();
        nb = 2;
        while (busy === 1'b1 && nb < 50) begin nb++; tick(); end
        n_total++; if (nb != MULT_N) $display("FAIL ignore_busy got=%0d want=%0d", nb, MULT_N); else n_pass++;
        n_total++; if ({hi, lo} !== 64'd63) $display("FAIL ignore_res got=%h_%h want=0_3f", hi, lo); else n_pass++;
        drive(1'b1, 3'd6, 32'hDEAD, 32'd1, 1'b1);
        n_total++; if (f_halt !== 1'b0) $display("FAIL nop_stall got=%b want=0", f_halt); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (busy !== 1'b0 || {hi, lo} !== 64'd63)
            $display("FAIL nop_effect busy=%b res=%h_%h want busy=0 res=0_3f", busy, hi, lo); else n_pass++;
    endtask

    task automatic test_stall();
        int ns, nb;
        do_reset();
        drive(1'b1, 3'd0, 32'd3, 32'd4, 1'b1);
        ns = (f_halt && d_halt && e_flush) ? 1 : 0;
        tick();
        drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b1);
        nb = 0;
        while (busy === 1'b1 && nb < 50) begin
            if (f_halt && d_halt && e_flush) ns++;
            nb++;
            tick();
        end
        n_total++; if (ns != MULT_N + 1) $display("FAIL stall_len got=%0d want=%0d", ns, MULT_N + 1); else n_pass++;
        n_total++; if ({f_halt, d_halt, e_flush} !== 3'b000)
            $display("FAIL stall_drop got=%b want=000", {f_halt, d_halt, e_flush}); else n_pass++;
        n_total++; if (lo !== 32'd12) $display("FAIL stall_res got=%h want=c", lo); else n_pass++;
`ifdef MD_STALL_CNT_EN
        n_total++; if (stall_cnt !== 32'd6) $display("FAIL stall_cnt got=%0d want=6", stall_cnt); else n_pass++;
`endif
        idle_inputs();
    endtask

    task automatic test_reset_mid_div();
        drive(1'b1, 3'd4, 32'h11, 32'd0, 1'b0); tick();
        drive(1'b1, 3'd2, 32'd1000, 32'd7, 1'b0); tick();
        idle_inputs();
        repeat (4) tick();
        do_reset();
        n_total++; if ({hi, lo} !== 64'd0) $display("FAIL middiv_res got=%h_%h want=0_0", hi, lo); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL middiv_busy got=%b want=0", busy); else n_pass++;
        repeat (12) tick();
        n_total++; if ({hi, lo} !== 64'd0) $display("FAIL middiv_stale got=%h_%h want=0_0", hi, lo); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] b;
        int r;
        bit es;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 7);
            b = (r == 0) ? 32'd0 : (r < 3) ? $urandom_range(1, 9) : $urandom;
            es = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 199) == 0);
            drive(es, 3'($urandom_range(0, 7)), $urandom, b, $urandom_range(0, 1) == 1);
            n_total++;
            if (hi !== m_hi || lo !== m_lo || busy !== (m_left > 0) ||
                f_halt !== exp_stall() || d_halt !== exp_stall() || e_flush !== exp_stall())
                $display("FAIL rand_cyc%0d got hi=%h lo=%h busy=%b st=%b%b%b want hi=%h lo=%h busy=%b st=%b",
                         i, hi, lo, busy, f_halt, d_halt, e_flush, m_hi, m_lo, m_left > 0, exp_stall());
            else n_pass++;
`ifdef MD_STALL_CNT_EN
            n_total++;
            if (stall_cnt !== m_scnt) $display("FAIL rand_scnt%0d got=%0d want=%0d", i, stall_cnt, m_scnt);
            else n_pass++;
`endif
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0; m_scnt = 0;
        idle_inputs();
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored();
        test_stall();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
